// File: rtl/spike_frame_buffer.sv
`default_nettype none
// ============================================================================
// spike_frame_buffer : DEPTH-deep FIFO of N_IN-channel spike frames, one
//   registered pop per timestep. Optional popcount under SPIKE_COUNT_EN.
// Revision 1.0 - initial release
// ============================================================================
module spike_frame_buffer #(
  parameter int N_IN  = 16,
  parameter int DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          data_in [N_IN],
  input  logic                          rd_en,
  input  logic                          flush,
  output logic                          out_valid,
  output logic                          data_out [N_IN],
  output logic [$clog2(DEPTH):0]        level,
  output logic                          full,
  output logic                          empty,
  output logic                          drop_err,
  output logic [$clog2(N_IN+1)-1:0]     spike_cnt
);

  localparam int c_ADDR_W = $clog2(DEPTH);
  localparam int c_LVL_W  = c_ADDR_W + 1;
  localparam int c_CNT_W  = $clog2(N_IN + 1);

  logic [N_IN-1:0]     r_mem [DEPTH];
  logic [c_ADDR_W-1:0] r_wp;
  logic [c_ADDR_W-1:0] r_rp;
  logic [c_LVL_W-1:0]  r_level;
  logic                r_out_valid;
  logic [N_IN-1:0]     r_data;
  logic                r_drop_err;

  logic [N_IN-1:0]     w_din;
  logic [N_IN-1:0]     w_rd_frame;
  logic                w_full;
  logic                w_empty;
  logic                w_wr;
  logic                w_rd;

  for (genvar i = 0; i < N_IN; i++) begin : g_bits
    assign w_din[i]    = data_in[i];
    assign data_out[i] = r_data[i];
  end

  assign w_full     = (r_level == c_LVL_W'(DEPTH));
  assign w_empty    = (r_level == '0);
  // Flush dominates: neither side is accepted in a flush cycle.
  assign w_wr       = in_valid && !w_full && !flush;
  assign w_rd       = rd_en && !w_empty && !flush;
  assign w_rd_frame = r_mem[r_rp];

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wp] <= w_din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp        <= '0;
      r_rp        <= '0;
      r_level     <= '0;
      r_out_valid <= 1'b0;
      r_data      <= '0;
      r_drop_err  <= 1'b0;
    end else if (flush) begin
      r_wp        <= '0;
      r_rp        <= '0;
      r_level     <= '0;
      r_out_valid <= 1'b0;
      r_data      <= '0;
      r_drop_err  <= 1'b0;
    end else begin
      if (w_wr) begin
        r_wp <= r_wp + 1'b1;
      end
      if (w_rd) begin
        r_rp        <= r_rp + 1'b1;
        r_data      <= w_rd_frame;
        r_out_valid <= 1'b1;
      end else begin
        r_data      <= '0;
        r_out_valid <= 1'b0;
      end
      if (w_wr && !w_rd) begin
        r_level <= r_level + 1'b1;
      end else if (w_rd && !w_wr) begin
        r_level <= r_level - 1'b1;
      end
      if (in_valid && w_full) begin
        r_drop_err <= 1'b1;
      end
    end
  end

`ifdef SPIKE_COUNT_EN
  logic [c_CNT_W-1:0] w_pop;
  logic [c_CNT_W-1:0] r_cnt;

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < N_IN; i++) begin
      w_pop = w_pop + c_CNT_W'(w_rd_frame[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_rd) begin
      r_cnt <= w_pop;
    end else begin
      r_cnt <= '0;
    end
  end

  assign spike_cnt = r_cnt;
`else
  assign spike_cnt = '0;
`endif

  assign in_ready  = !w_full;
  assign full      = w_full;
  assign empty     = w_empty;
  assign level     = r_level;
  assign out_valid = r_out_valid;
  assign drop_err  = r_drop_err;

endmodule
`default_nettype wire

// File: tb/tb_spike_frame_buffer.sv
`default_nettype none
// ============================================================================
// tb_spike_frame_buffer : scoreboard bench for spike_frame_buffer.
// Revision 1.0 - initial release
// ============================================================================
module tb_spike_frame_buffer;

  localparam int c_N_IN  = 16;
  localparam int c_DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        data_in [c_N_IN];
  logic        rd_en = 1'b0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        data_out [c_N_IN];
  logic [3:0]  level;
  logic        full;
  logic        empty;
  logic        drop_err;
  logic [4:0]  spike_cnt;

  spike_frame_buffer #(.N_IN(c_N_IN), .DEPTH(c_DEPTH)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .rd_en     (rd_en),
    .flush     (flush),
    .out_valid (out_valid),
    .data_out  (data_out),
    .level     (level),
    .full      (full),
    .empty     (empty),
    .drop_err  (drop_err),
    .spike_cnt (spike_cnt)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] sb [$];
  int          m_lvl  = 0;
  logic        m_drop = 1'b0;
  logic        m_ov   = 1'b0;
  logic [15:0] m_data = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] dout_packed();
    logic [15:0] v;
    for (int i = 0; i < c_N_IN; i++) v[i] = data_out[i];
    return v;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_ov));
    chk({tag, ".data_out"},  32'(dout_packed()), 32'(m_data));
    chk({tag, ".level"},     32'(level), 32'(m_lvl));
    chk({tag, ".full"},      32'(full), 32'(m_lvl == c_DEPTH));
    chk({tag, ".empty"},     32'(empty), 32'(m_lvl == 0));
    chk({tag, ".in_ready"},  32'(in_ready), 32'(m_lvl != c_DEPTH));
    chk({tag, ".drop_err"},  32'(drop_err), 32'(m_drop));
`ifdef SPIKE_COUNT_EN
    chk({tag, ".spike_cnt"}, 32'(spike_cnt), 32'($countones(m_data)));
`else
    chk({tag, ".spike_cnt"}, 32'(spike_cnt), 32'd0);
`endif
  endtask

  task automatic model_reset();
    sb.delete();
    m_lvl  = 0;
    m_drop = 1'b0;
    m_ov   = 1'b0;
    m_data = '0;
  endtask

  // Drive one cycle, predict the result, clock it, then compare #1 later.
  task automatic step(input logic v, input logic [15:0] d, input logic r,
                      input logic f, input string tag);
    logic acc_rd, acc_wr;
    in_valid = v;
    rd_en    = r;
    flush    = f;
    for (int i = 0; i < c_N_IN; i++) data_in[i] = d[i];
    if (f) begin
      model_reset();
    end else begin
      acc_rd = r && (m_lvl > 0);
      acc_wr = v && (m_lvl < c_DEPTH);
      if (v && m_lvl == c_DEPTH) m_drop = 1'b1;
      if (acc_rd) begin
        m_ov   = 1'b1;
        m_data = sb.pop_front();
      end else begin
        m_ov   = 1'b0;
        m_data = '0;
      end
      if (acc_wr) sb.push_back(d);
      m_lvl = m_lvl + int'(acc_wr) - int'(acc_rd);
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    for (int i = 0; i < c_N_IN; i++) data_in[i] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all("reset_held");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_all("reset_rel");

    // single frame
    step(1'b1, 16'h8001, 1'b0, 1'b0, "single_wr");
    step(1'b0, 16'h0000, 1'b0, 1'b0, "single_gap");
    step(1'b0, 16'h0000, 1'b1, 1'b0, "single_rd");
    step(1'b0, 16'h0000, 1'b0, 1'b0, "single_after");

    // fill, overflow, drain
    for (int k = 1; k <= 8; k++) step(1'b1, 16'(k), 1'b0, 1'b0, "fill");
    step(1'b1, 16'h00ff, 1'b0, 1'b0, "overflow");
    for (int k = 0; k < 8; k++) step(1'b0, 16'h0000, 1'b1, 1'b0, "drain");
    step(1'b0, 16'h0000, 1'b0, 1'b0, "drained");

    // wrap-around at constant level 3
    for (int k = 0; k < 3; k++) step(1'b1, 16'($urandom), 1'b0, 1'b0, "wrap_pre");
    for (int k = 0; k < 20; k++) step(1'b1, 16'($urandom), 1'b1, 1'b0, "wrap");
    for (int k = 0; k < 3; k++) step(1'b0, 16'h0000, 1'b1, 1'b0, "wrap_post");

    // simultaneous rd/wr at level 4, then at full
    for (int k = 0; k < 4; k++) step(1'b1, 16'h1111 * 16'(k + 1), 1'b0, 1'b0, "lv4_fill");
    step(1'b1, 16'hA5A5, 1'b1, 1'b0, "lv4_rdwr");
    for (int k = 0; k < 4; k++) step(1'b1, 16'h0F0F ^ 16'(k), 1'b0, 1'b0, "full_fill");
    step(1'b1, 16'hDEAD, 1'b1, 1'b0, "full_rdwr");
    for (int k = 0; k < 7; k++) step(1'b0, 16'h0000, 1'b1, 1'b0, "full_drain");

    // read while empty
    step(1'b0, 16'h0000, 1'b1, 1'b0, "rd_empty0");
    step(1'b0, 16'h0000, 1'b1, 1'b0, "rd_empty1");

    // flush with 5 stored plus simultaneous rd/wr
    for (int k = 0; k < 5; k++) step(1'b1, 16'hC000 | 16'(k), 1'b0, 1'b0, "fl_fill");
    step(1'b1, 16'hFFFF, 1'b1, 1'b1, "flush");
    step(1'b0, 16'h0000, 1'b1, 1'b0, "flush_after");

    // asynchronous reset mid-read
    step(1'b1, 16'h1234, 1'b0, 1'b0, "ar_wr0");
    step(1'b1, 16'h5678, 1'b0, 1'b0, "ar_wr1");
    step(1'b0, 16'h0000, 1'b1, 1'b0, "ar_rd");
    in_valid = 1'b0;
    rd_en    = 1'b0;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("ar_async");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b1, 16'hABCD, 1'b0, 1'b0, "ar_rewr");
    step(1'b0, 16'h0000, 1'b1, 1'b0, "ar_reread");
    step(1'b0, 16'h0000, 1'b0, 1'b0, "ar_idle");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spike_frame_buffer.md
# spike_frame_buffer

Parametrised input spike buffer between the external spike source and the first LIF layer. It stores up to DEPTH spike frames of N_IN channels each in a FIFO with a ready/valid write side. The layer controller pops one frame per timestep; each pop yields a registered frame and a one-cycle `out_valid` pulse. The block adds buffering, back-pressure, flush and overflow detection over a single-frame input latch.

## Interface
- N_IN, 16, spike channels per frame (≥1)
- DEPTH, 8, frames stored; power of two, ≥2
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  source presents a frame on data_in
- in_ready  out  1  buffer can accept a frame (= !full)
- data_in  in  N_IN x 1 (unpacked)  incoming spike frame, bit i = channel i
- rd_en  in  1  layer requests next frame (one per timestep)
- flush  in  1  synchronous clear of all stored frames
- out_valid  out  1  one-cycle pulse, data_out holds a popped frame
- data_out  out  N_IN x 1 (unpacked)  popped frame; all zeros when out_valid=0
- level  out  $clog2(DEPTH)+1  frames currently stored
- full  out  1  level == DEPTH
- empty  out  1  level == 0
- drop_err  out  1  sticky: write attempted while full
- spike_cnt  out  $clog2(N_IN+1)  popcount of data_out (see Configuration)

## Operation
- Storage: DEPTH x N_IN register array; write pointer wp, read pointer rp, each $clog2(DEPTH) bits, wrapping DEPTH-1 → 0; level kept as a separate counter.
- Write: accepted on a cycle with in_valid && in_ready; frame goes to mem[wp], wp++, level++.
- Read: accepted on a cycle with rd_en && !empty; data_out <= mem[rp], out_valid <= 1, rp++, level--.
- No accepted read: data_out <= all zeros, out_valid <= 0, spike_cnt <= 0.
- Read while empty: ignored, no error, out_valid stays 0. No fall-through: a frame written in cycle t is readable no earlier than cycle t+1.
- Simultaneous accepted read and write: both pointers advance, level unchanged.
- Full: in_ready=0, so no write is accepted even when a read occurs in the same cycle. in_valid && full sets drop_err; the frame is discarded.
- Flush: highest priority. wp, rp, level <= 0; out_valid <= 0; data_out <= 0; drop_err <= 0. Any read or write in the same cycle is ignored. Memory contents need not be cleared.
- drop_err clears only on flush or reset.

## Timing
- Reset (rst_n=0, asynchronous): wp=rp=level=0, in_ready=1, full=0, empty=1, out_valid=0, data_out=0, drop_err=0, spike_cnt=0. Memory contents are don't-care.
- in_ready, full, empty and level are registered state and reflect writes and reads accepted up to the previous edge.
- Read latency: rd_en sampled at edge t → data_out/out_valid valid after edge t, for one cycle.
- Back-to-back rd_en gives consecutive frames on consecutive cycles; throughput is one write plus one read per cycle.
- Reset asserted mid-stream drops all stored frames; after release, the first write lands at slot 0.

## Configuration
- SPIKE_COUNT_EN defined: spike_cnt is registered with data_out and equals the number of ones in the popped frame; it is 0 when out_valid=0.
- Undefined: spike_cnt is tied to 0 and the popcount logic is not built. All other behaviour is identical.

## Test plan
- Reset then single frame: write 16'h8001, rd_en two cycles later → out_valid pulse one cycle after rd_en, data_out=16'h8001, spike_cnt=2 (with SPIKE_COUNT_EN), level 1→0.
- Fill to DEPTH=8 frames 1..8 → full=1, in_ready=0; 9th in_valid → drop_err=1; draining 8 frames returns 1..8 in order, then empty=1.
- Wrap-around: 20 interleaved writes and reads with level kept at 3 → output order matches input order across pointer wrap; level stays 3.
- Simultaneous read and write at level 4 → level stays 4; read and write at full → read accepted, write refused, level=7.
- rd_en while empty → out_valid=0, data_out=0, level=0, drop_err unchanged.
- Flush with 5 frames stored plus simultaneous rd_en and in_valid → next cycle level=0, out_valid=0, drop_err=0; async rst_n mid-read clears out_valid immediately.
